register_file: RTL and testbench

- 16-entry x 16-bit general-purpose register file for the processor datapath. It has two combinational read ports and one synchronous write port.
- Read ports include write-to-read bypass, so an instruction reading a register in the same cycle it is written sees the new value.
- Sits between decode (source/destination register specifiers) and writeback (DstData).

---
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// General-purpose register file for the processor datapath: 2**ADDR_WIDTH
// registers of DATA_WIDTH bits. It has two combinational read ports and one
// synchronous write port, and the read ports bypass the write port. An
// instruction that reads a register in the same cycle that register is written
// therefore sees the new value before the clock edge. R0 is an ordinary
// writable register.
//
// Ports
//   clk       in     system clock; writes happen on the rising edge
//   rst       in     asynchronous, active-low reset; clears every register,
//                    suppresses writes and forces both read ports to zero
//   WriteReg  in     write enable for the write port
//   SrcReg1   in     read port 1 register specifier
//   SrcReg2   in     read port 2 register specifier
//   DstReg    in     write port register specifier
//   DstData   in     write port data
//   SrcData1  inout  read port 1 data; always driven by this block
//   SrcData2  inout  read port 2 data; always driven by this block
//
// The read data ports are inout only to match the datapath's bitline
// convention. This block drives them continuously and never releases them to
// high-Z, so external logic must not drive them.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WriteReg,
  input  logic [ADDR_WIDTH-1:0] SrcReg1,
  input  logic [ADDR_WIDTH-1:0] SrcReg2,
  input  logic [ADDR_WIDTH-1:0] DstReg,
  input  logic [DATA_WIDTH-1:0] DstData,
  inout  wire  [DATA_WIDTH-1:0] SrcData1,
  inout  wire  [DATA_WIDTH-1:0] SrcData2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A write is in flight this cycle only while out of reset. Gating the write
  // and the bypass with the same term means that a reset arriving between
  // edges drops a pending write and zeroes the outputs together.
  logic write_active;
  assign write_active = rst && WriteReg;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: this array gets an explicit reset because software relies on every
  // register reading 0 after reset. That keeps it out of RAM macros, which is
  // acceptable at this size. Sequential state is assigned with <= so that every
  // register samples its pre-edge inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_active) begin
      regs[DstReg] <= DstData;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-to-read bypass
  // ---------------------------------------------------------------------------
  // Each port bypasses independently. Both ports may select the same register,
  // with or without a bypass. Every path is fully specified, so the outputs
  // depend only on the current state and inputs.
  logic                  bypass1;
  logic                  bypass2;
  logic [DATA_WIDTH-1:0] read1;
  logic [DATA_WIDTH-1:0] read2;

  assign bypass1 = write_active && (SrcReg1 == DstReg);
  assign bypass2 = write_active && (SrcReg2 == DstReg);

  // The storage is already zero during reset. The explicit !rst term also
  // forces the ports to zero in the same instant that reset asserts, without
  // waiting for the array to settle.
  assign read1 = !rst    ? '0      :
                 bypass1 ? DstData : regs[SrcReg1];
  assign read2 = !rst    ? '0      :
                 bypass2 ? DstData : regs[SrcReg2];

  assign SrcData1 = read1;
  assign SrcData2 = read2;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file. A plain array holds the expected
// register contents, and a function gives the value each read port should show
// in the current cycle. Directed sequences exercise reset, fill, readback,
// bypass isolation, write gating and mid-run reset. A randomized phase
// follows.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        WriteReg;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  wire  [15:0] SrcData1;
  wire  [15:0] SrcData2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model_mem [16];

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .WriteReg (WriteReg),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Value a read port should show right now. Reset gives 0; otherwise a write
  // to the same register this cycle wins; otherwise the stored value is shown.
  function automatic logic [15:0] expect_read(input logic [3:0] src);
    if (!rst) return 16'h0000;
    if (WriteReg && (src == DstReg)) return DstData;
    return model_mem[src];
  endfunction

  // Drive inputs away from the rising edge, let them settle, then check both ports.
  task automatic apply(input logic r, input logic we, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] d, input logic [15:0] dd,
                       input string tag);
    rst = r; WriteReg = we; SrcReg1 = s1; SrcReg2 = s2; DstReg = d; DstData = dd;
    if (!r) begin
      for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    end
    #1;
    check({tag, "_p1"}, SrcData1, expect_read(s1));
    check({tag, "_p2"}, SrcData2, expect_read(s2));
  endtask

  // One clock edge: update the model with the write that commits, then return
  // to the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst && WriteReg) model_mem[DstReg] = DstData;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    rst = 1'b0; WriteReg = 1'b0; SrcReg1 = '0; SrcReg2 = '0; DstReg = '0; DstData = '0;

    // Reset sweep: the write port is active, but the writes must be ignored.
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, 4'(i), 4'(15 - i), 4'(i), 16'hFFFF, "reset_sweep");
      check("reset_zero", SrcData1, 16'h0000);
    end
    tick();

    // Reset deassertion: the first rising edge with rst high writes.
    apply(1'b1, 1'b1, 4'd7, 4'd7, 4'd7, 16'h5A5A, "deassert_bypass");
    tick();
    apply(1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 16'h0000, "deassert_write");
    check("deassert_r7", SrcData1, 16'h5A5A);

    // Sequential fill, checking the bypass before each edge and the stored
    // value after it.
    for (int r = 0; r < 16; r++) begin
      logic [15:0] v;
      v = r[0] ? 16'hBEEF : 16'hDEAD;
      apply(1'b1, 1'b1, 4'(r), 4'(r), 4'(r), v, "fill_bypass");
      tick();
      apply(1'b1, 1'b0, 4'(r), 4'(r), 4'(r), v, "fill_stored");
    end

    // Readback on both ports, checked against the pattern.
    for (int r = 0; r < 16; r++) begin
      apply(1'b1, 1'b0, 4'(r), 4'(15 - r), 4'd0, 16'h0000, "readback");
      check("readback_p1_pat", SrcData1, r[0] ? 16'hBEEF : 16'hDEAD);
      check("readback_p2_pat", SrcData2, r[0] ? 16'hDEAD : 16'hBEEF);
    end

    // Bypass isolation: only port 1 selects the register being written.
    apply(1'b1, 1'b1, 4'd5, 4'd5, 4'd5, 16'h1234, "iso_write");
    tick();
    apply(1'b1, 1'b1, 4'd5, 4'd6, 4'd5, 16'hAAAA, "iso_bypass");
    check("iso_p1_aaaa", SrcData1, 16'hAAAA);
    check("iso_p2_r6", SrcData2, 16'hDEAD);
    apply(1'b1, 1'b0, 4'd5, 4'd6, 4'd5, 16'hAAAA, "iso_nobypass");
    check("iso_p1_1234", SrcData1, 16'h1234);

    // Write-enable gating: three edges with WriteReg low leave R3 unchanged.
    apply(1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 16'hFFFF, "gate");
    tick(); tick(); tick();
    apply(1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 16'hFFFF, "gate_after");
    check("gate_r3", SrcData1, 16'hBEEF);

    // Async reset between edges: reads drop to zero at once, and a write held
    // across the next edge under reset is lost.
    apply(1'b1, 1'b0, 4'd2, 4'd9, 4'd0, 16'h0000, "pre_rst");
    #2;
    apply(1'b0, 1'b1, 4'd2, 4'd9, 4'd9, 16'h7777, "mid_rst");
    check("mid_rst_p1", SrcData1, 16'h0000);
    check("mid_rst_p2", SrcData2, 16'h0000);
    tick();
    apply(1'b1, 1'b0, 4'd9, 4'd2, 4'd9, 16'h7777, "post_rst");
    check("post_rst_r9", SrcData1, 16'h0000);

    // Randomized phase with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 39) != 0);
      apply(r, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            16'($urandom), "rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
